// File: rtl/xcorr_sync_ctrl.sv
// xcorr_sync_ctrl: arms the correlation peak finder, turns its strobe into a frame window plus guard holdoff.
// Optional noise-adaptive threshold under XCORR_SYNC_NOISE_ADAPT_EN.
module xcorr_sync_ctrl #(
    parameter int WDTH_CRR = 24,
    parameter int LEN_W    = 16,
    parameter int GUARD_W  = 8,
    parameter int ALPHA_SH = 4,
    parameter int THR_SH   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [WDTH_CRR-1:0] base_thr,
    input  logic [LEN_W-1:0]    frame_len,
    input  logic [GUARD_W-1:0]  guard_len,
    input  logic [WDTH_CRR-1:0] corr_in,
    input  logic                det_sop,
    output logic                det_rst,
    output logic [WDTH_CRR-1:0] thr_lvl,
    output logic                frame_sop,
    output logic                frame_val,
    output logic                frame_eop,
    output logic [LEN_W-1:0]    sample_idx,
    output logic                busy,
    output logic [15:0]         det_cnt
);
    typedef enum logic [1:0] {IDLE, ARMED, FRAME, GUARD} state_t;
    localparam logic [WDTH_CRR-1:0] ONES = {WDTH_CRR{1'b1}};
    state_t               state, next_state;
    logic [LEN_W-1:0]     len_q, len_cur, idx_nxt;
    logic [GUARD_W-1:0]   guard_q, gcnt;
    logic [WDTH_CRR-1:0]  eff_thr;
    logic                 take;
    assign take = (state == ARMED) && det_sop;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = enable ? ARMED : IDLE;
            ARMED: next_state = det_sop ? FRAME : (enable ? ARMED : IDLE);
            FRAME: if (frame_eop) next_state = (guard_q != '0) ? GUARD : (enable ? ARMED : IDLE);
            GUARD: if (gcnt == guard_q - GUARD_W'(1)) next_state = enable ? ARMED : IDLE;
            default: next_state = IDLE;
        endcase
    end
    // Outputs are computed from next_state so they register in step with the state.
    always_comb begin
        len_cur = take ? ((frame_len == '0) ? LEN_W'(1) : frame_len) : len_q;
        idx_nxt = (state == FRAME && next_state == FRAME) ? sample_idx + LEN_W'(1) : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_rst    <= 1'b1;
            thr_lvl    <= ONES;
            frame_sop  <= 1'b0;
            frame_val  <= 1'b0;
            frame_eop  <= 1'b0;
            sample_idx <= '0;
            busy       <= 1'b0;
            det_cnt    <= '0;
            len_q      <= LEN_W'(1);
            guard_q    <= '0;
            gcnt       <= '0;
        end else begin
            det_rst    <= next_state != ARMED;
            thr_lvl    <= (next_state == ARMED) ? eff_thr : ONES;
            frame_sop  <= take;
            frame_val  <= next_state == FRAME;
            frame_eop  <= (next_state == FRAME) && (idx_nxt == len_cur - LEN_W'(1));
            sample_idx <= idx_nxt;
            busy       <= next_state != IDLE;
            det_cnt    <= (take && det_cnt != 16'hFFFF) ? det_cnt + 16'd1 : det_cnt;
            len_q      <= len_cur;
            guard_q    <= take ? guard_len : guard_q;
            gcnt       <= (state == GUARD) ? gcnt + GUARD_W'(1) : '0;
        end
    end
`ifdef XCORR_SYNC_NOISE_ADAPT_EN
    logic [WDTH_CRR-1:0]        noise_avg, shl_sat;
    logic signed [WDTH_CRR:0]   diff;
    logic signed [WDTH_CRR+1:0] sum;
    logic [WDTH_CRR+THR_SH-1:0] shl;
    always_comb begin
        diff    = $signed({1'b0, corr_in}) - $signed({1'b0, noise_avg});
        sum     = $signed({2'b00, noise_avg}) + (diff >>> ALPHA_SH);
        shl     = {{THR_SH{1'b0}}, noise_avg} << THR_SH;
        shl_sat = (|shl[WDTH_CRR+THR_SH-1:WDTH_CRR]) ? ONES : shl[WDTH_CRR-1:0];
    end
    // Estimator only tracks quiet samples so peaks do not inflate the floor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noise_avg <= '0;
            eff_thr   <= ONES;
        end else begin
            if (state == ARMED && corr_in <= thr_lvl)
                noise_avg <= sum[WDTH_CRR+1] ? '0 : (sum[WDTH_CRR] ? ONES : sum[WDTH_CRR-1:0]);
            eff_thr <= (shl_sat > base_thr) ? shl_sat : base_thr;
        end
    end
`else
    assign eff_thr = base_thr;
    logic unused_noise;
    assign unused_noise = ^{corr_in, 32'(ALPHA_SH + THR_SH)};
`endif
endmodule
